// File: rtl/dump_ctrl_pkg.sv
// Shared types for the dump window controller: FSM state encoding and retrigger modes.
// No logic; a 2-line header keeps the slice consistent.
package dump_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSED = 2'd2
  } dump_state_e;

  localparam int unsigned RESTART_IGNORE = 0;
  localparam int unsigned RESTART_EXTEND = 1;

endpackage

// File: rtl/dump_period_timer.sv
// Free-running modulo-PERIOD counter, started once by `start`; registered tick, 1-cycle latency.
// Tick fires PERIOD cycles after the cycle following start, then every PERIOD cycles; PERIOD=0 never ticks.
module dump_period_timer #(
  parameter int unsigned PERIOD = 10000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic tick
);

  localparam int unsigned LAST_I  = (PERIOD > 0) ? PERIOD - 1 : 0;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);
  localparam bit          ENABLED = (PERIOD != 0);

  logic             running_q, running_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    running_d = running_q | start;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    if (running_q) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = ENABLED;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/dump_window_ctrl.sv
// Trigger-driven dump window controller emitting vars/on/off/all control pulses and a window level.
// All outputs registered, 1-cycle latency from trigger; no backpressure, triggers are sampled every cycle.
module dump_window_ctrl
  import dump_ctrl_pkg::*;
#(
  parameter int unsigned WINDOW      = 500,
  parameter int unsigned CKPT_PERIOD = 10000,
  parameter int unsigned RESTART     = 0,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WCNT_W      = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              trigger,
  output logic              dump_on,
  output logic              dump_vars_pulse,
  output logic              dump_on_pulse,
  output logic              dump_off_pulse,
  output logic              dump_all_pulse,
  output logic              armed,
  output logic [WCNT_W-1:0] window_count
);

  localparam logic [CNT_W-1:0] WIN_LD = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  dump_state_e       state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              on_q, on_d;
  logic              vars_q, vars_d;
  logic              onp_q, onp_d;
  logic              offp_q, offp_d;
  logic              armed_q, armed_d;
  logic [WCNT_W-1:0] wcount_q, wcount_d;
  logic              start_win;
  logic              ckpt_start;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    vars_d      = 1'b0;
    onp_d       = 1'b0;
    armed_d     = armed_q;
    wcount_d    = wcount_q;
    start_win   = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          start_win = 1'b1;
          vars_d    = 1'b1;
          armed_d   = 1'b1;
        end
      end
      PAUSED: begin
        if (trigger) start_win = 1'b1;
      end
      ACTIVE: begin
        // A trigger on the last cycle chains a fresh window in either mode.
        if (remaining_q == ONE) begin
          if (trigger) begin
            start_win = 1'b1;
          end else begin
            state_d     = PAUSED;
            remaining_d = '0;
          end
        end else if (trigger && (RESTART != RESTART_IGNORE)) begin
          remaining_d = WIN_LD;
        end else begin
          remaining_d = remaining_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_win) begin
      state_d     = ACTIVE;
      remaining_d = WIN_LD;
      onp_d       = 1'b1;
      if (wcount_q != '1) wcount_d = wcount_q + 1'b1;
    end

    on_d   = (state_d == ACTIVE);
    offp_d = on_d && (remaining_d == ONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      on_q        <= 1'b0;
      vars_q      <= 1'b0;
      onp_q       <= 1'b0;
      offp_q      <= 1'b0;
      armed_q     <= 1'b0;
      wcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      on_q        <= on_d;
      vars_q      <= vars_d;
      onp_q       <= onp_d;
      offp_q      <= offp_d;
      armed_q     <= armed_d;
      wcount_q    <= wcount_d;
    end
  end

  assign ckpt_start = (state_q == IDLE) && trigger;

  dump_period_timer #(
    .PERIOD (CKPT_PERIOD),
    .CNT_W  (CNT_W)
  ) u_ckpt_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (ckpt_start),
    .tick    (dump_all_pulse)
  );

  assign dump_on         = on_q;
  assign dump_vars_pulse = vars_q;
  assign dump_on_pulse   = onp_q;
  assign dump_off_pulse  = offp_q;
  assign armed           = armed_q;
  assign window_count    = wcount_q;

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Bench for dump_window_ctrl: three instances (ignore-mode, extend-mode, one-cycle window with small counter).
// Expected per-cycle output vectors are queued from the timing rules and popped as each cycle is sampled.
module tb_dump_window_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic trig_a = 1'b0, trig_b = 1'b0, trig_c = 1'b0;

  logic       on_a, vars_a, onp_a, offp_a, allp_a, armed_a;
  logic [7:0] wc_a;
  logic       on_b, vars_b, onp_b, offp_b, allp_b, armed_b;
  logic [7:0] wc_b;
  logic       on_c, vars_c, onp_c, offp_c, allp_c, armed_c;
  logic [1:0] wc_c;

  always #5 clk = ~clk;

  dump_window_ctrl #(.WINDOW(4), .CKPT_PERIOD(10), .RESTART(0), .CNT_W(16), .WCNT_W(8)) dut_a (
    .clock(clk), .reset_n(reset_n), .trigger(trig_a),
    .dump_on(on_a), .dump_vars_pulse(vars_a), .dump_on_pulse(onp_a), .dump_off_pulse(offp_a),
    .dump_all_pulse(allp_a), .armed(armed_a), .window_count(wc_a));

  dump_window_ctrl #(.WINDOW(4), .CKPT_PERIOD(10), .RESTART(1), .CNT_W(16), .WCNT_W(8)) dut_b (
    .clock(clk), .reset_n(reset_n), .trigger(trig_b),
    .dump_on(on_b), .dump_vars_pulse(vars_b), .dump_on_pulse(onp_b), .dump_off_pulse(offp_b),
    .dump_all_pulse(allp_b), .armed(armed_b), .window_count(wc_b));

  dump_window_ctrl #(.WINDOW(1), .CKPT_PERIOD(0), .RESTART(0), .CNT_W(16), .WCNT_W(2)) dut_c (
    .clock(clk), .reset_n(reset_n), .trigger(trig_c),
    .dump_on(on_c), .dump_vars_pulse(vars_c), .dump_on_pulse(onp_c), .dump_off_pulse(offp_c),
    .dump_all_pulse(allp_c), .armed(armed_c), .window_count(wc_c));

  // Vector layout: {dump_on, vars, on_pulse, off_pulse, all_pulse, armed, window_count[7:0]}
  wire [13:0] obs_a = {on_a, vars_a, onp_a, offp_a, allp_a, armed_a, wc_a};
  wire [13:0] obs_b = {on_b, vars_b, onp_b, offp_b, allp_b, armed_b, wc_b};
  wire [13:0] obs_c = {on_c, vars_c, onp_c, offp_c, allp_c, armed_c, 6'd0, wc_c};

  int tests_run = 0;
  int tests_failed = 0;
  logic [13:0] q_a[$];
  logic [13:0] q_b[$];
  logic [13:0] q_c[$];

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Expected outputs in cycle c; `first` is the cycle of the first on pulse (999 = never triggered).
  function automatic logic [13:0] exp_vec(input int c, input logic [63:0] on_m, input logic [63:0] onp_m,
                                          input logic [63:0] offp_m, input int first, input int per,
                                          input int wmax);
    int   n;
    logic allp;
    n = 0;
    for (int i = 0; i <= c; i++) if (onp_m[i]) n++;
    if (n > wmax) n = wmax;
    allp = (per != 0) && (c > first) && (((c - first) % per) == 0);
    return {on_m[c], (c == first), onp_m[c], offp_m[c], allp, (c >= first), 8'(n)};
  endfunction

  // Leaves the bench just after edge 0, i.e. sampling cycle 1.
  task automatic do_reset();
    trig_a = 1'b0; trig_b = 1'b0; trig_c = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (obs_a !== 14'd0) begin tests_failed++; $display("FAIL reset_a got %b expected %b", obs_a, 14'd0); end
    tests_run++;
    if (obs_b !== 14'd0) begin tests_failed++; $display("FAIL reset_b got %b expected %b", obs_b, 14'd0); end
    tests_run++;
    if (obs_c !== 14'd0) begin tests_failed++; $display("FAIL reset_c got %b expected %b", obs_c, 14'd0); end
  endtask

  task automatic test_basic();
    logic [63:0] ea, on, onp, offp;
    logic [13:0] e;
    do_reset();
    ea = '0; ea[5] = 1'b1; ea[20] = 1'b1;
    on = rng(6, 9) | rng(21, 24);
    onp = '0; onp[6] = 1'b1; onp[21] = 1'b1;
    offp = '0; offp[9] = 1'b1; offp[24] = 1'b1;
    for (int c = 1; c <= 30; c++) q_a.push_back(exp_vec(c, on, onp, offp, 6, 10, 255));
    for (int c = 1; c <= 30; c++) begin
      e = q_a.pop_front();
      tests_run++;
      if (obs_a !== e) begin
        tests_failed++;
        $display("FAIL basic cycle %0d got %b expected %b", c, obs_a, e);
      end
      trig_a = ea[c];
      @(posedge clk); #1;
    end
    trig_a = 1'b0;
  endtask

  task automatic test_restart();
    logic [63:0] ev, on_a_m, off_a_m, on_b_m, off_b_m, onp;
    logic [13:0] e;
    do_reset();
    ev = '0; ev[5] = 1'b1; ev[7] = 1'b1;
    onp = '0; onp[6] = 1'b1;
    on_a_m = rng(6, 9);  off_a_m = '0; off_a_m[9] = 1'b1;
    on_b_m = rng(6, 11); off_b_m = '0; off_b_m[11] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      q_a.push_back(exp_vec(c, on_a_m, onp, off_a_m, 6, 10, 255));
      q_b.push_back(exp_vec(c, on_b_m, onp, off_b_m, 6, 10, 255));
    end
    for (int c = 1; c <= 20; c++) begin
      e = q_a.pop_front();
      tests_run++;
      if (obs_a !== e) begin
        tests_failed++;
        $display("FAIL restart_ignore cycle %0d got %b expected %b", c, obs_a, e);
      end
      e = q_b.pop_front();
      tests_run++;
      if (obs_b !== e) begin
        tests_failed++;
        $display("FAIL restart_extend cycle %0d got %b expected %b", c, obs_b, e);
      end
      trig_a = ev[c]; trig_b = ev[c];
      @(posedge clk); #1;
    end
    trig_a = 1'b0; trig_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ev, on, onp, offp;
    logic [13:0] e;
    do_reset();
    ev = '0; ev[5] = 1'b1; ev[9] = 1'b1;
    on = rng(6, 13);
    onp = '0; onp[6] = 1'b1; onp[10] = 1'b1;
    offp = '0; offp[9] = 1'b1; offp[13] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      q_a.push_back(exp_vec(c, on, onp, offp, 6, 10, 255));
      q_b.push_back(exp_vec(c, on, onp, offp, 6, 10, 255));
    end
    for (int c = 1; c <= 20; c++) begin
      e = q_a.pop_front();
      tests_run++;
      if (obs_a !== e) begin
        tests_failed++;
        $display("FAIL b2b_ignore cycle %0d got %b expected %b", c, obs_a, e);
      end
      e = q_b.pop_front();
      tests_run++;
      if (obs_b !== e) begin
        tests_failed++;
        $display("FAIL b2b_extend cycle %0d got %b expected %b", c, obs_b, e);
      end
      trig_a = ev[c]; trig_b = ev[c];
      @(posedge clk); #1;
    end
    trig_a = 1'b0; trig_b = 1'b0;
  endtask

  task automatic test_checkpoint();
    logic [63:0] ea, on, onp, offp;
    logic [13:0] e;
    do_reset();
    ea = '0; ea[5] = 1'b1;
    on = rng(6, 9);
    onp = '0; onp[6] = 1'b1;
    offp = '0; offp[9] = 1'b1;
    for (int c = 1; c <= 40; c++) q_a.push_back(exp_vec(c, on, onp, offp, 6, 10, 255));
    for (int c = 1; c <= 40; c++) begin
      e = q_a.pop_front();
      tests_run++;
      if (obs_a !== e) begin
        tests_failed++;
        $display("FAIL checkpoint cycle %0d got %b expected %b", c, obs_a, e);
      end
      trig_a = ea[c];
      @(posedge clk); #1;
    end
    trig_a = 1'b0;
  endtask

  task automatic test_window1_saturate();
    logic [63:0] ec, m;
    logic [13:0] e;
    do_reset();
    ec = '0; ec[5] = 1'b1; ec[6] = 1'b1; ec[10] = 1'b1; ec[12] = 1'b1; ec[13] = 1'b1; ec[14] = 1'b1;
    m = '0; m[6] = 1'b1; m[7] = 1'b1; m[11] = 1'b1; m[13] = 1'b1; m[14] = 1'b1; m[15] = 1'b1;
    for (int c = 1; c <= 20; c++) q_c.push_back(exp_vec(c, m, m, m, 6, 0, 3));
    for (int c = 1; c <= 20; c++) begin
      e = q_c.pop_front();
      tests_run++;
      if (obs_c !== e) begin
        tests_failed++;
        $display("FAIL window1 cycle %0d got %b expected %b", c, obs_c, e);
      end
      trig_c = ec[c];
      @(posedge clk); #1;
    end
    trig_c = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] ea, on, onp, offp;
    logic [13:0] e;
    do_reset();
    ea = '0; ea[5] = 1'b1;
    on = rng(6, 9);
    onp = '0; onp[6] = 1'b1;
    offp = '0; offp[9] = 1'b1;
    for (int c = 1; c <= 7; c++) q_a.push_back(exp_vec(c, on, onp, offp, 6, 10, 255));
    for (int c = 1; c <= 7; c++) begin
      e = q_a.pop_front();
      tests_run++;
      if (obs_a !== e) begin
        tests_failed++;
        $display("FAIL midreset_pre cycle %0d got %b expected %b", c, obs_a, e);
      end
      if (c != 7) begin
        trig_a = ea[c];
        @(posedge clk); #1;
      end
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (obs_a !== 14'd0) begin
      tests_failed++;
      $display("FAIL midreset_async got %b expected %b", obs_a, 14'd0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 1; c <= 10; c++) q_a.push_back(exp_vec(c, on, onp, offp, 6, 10, 255));
    for (int c = 1; c <= 10; c++) begin
      e = q_a.pop_front();
      tests_run++;
      if (obs_a !== e) begin
        tests_failed++;
        $display("FAIL midreset_post cycle %0d got %b expected %b", c, obs_a, e);
      end
      trig_a = ea[c];
      @(posedge clk); #1;
    end
    trig_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_back_to_back();
    test_checkpoint();
    test_window1_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
